vec_mem_sequencer: RTL and testbench

- Controller that serializes one vector memory access (R lanes of N bits) from the MEM stage onto a single N-bit-wide data-memory port.
- Stalls the pipeline while the access runs. On a load, it presents the gathered R-lane result on ReadDataM, which feeds the MEM/WB segment register.
- Sits between the EX/MEM segment outputs and the byte-wide data RAM.
- All state updates occur on the falling edge of clk, matching the pipeline segment registers.

---
 rtl/vec_mem_pkg.sv | 11 +
 rtl/vec_mem_sequencer_lane_timeout_counter.sv | 28 ++
 rtl/vec_mem_sequencer.sv | 128 ++++++++++++
 tb/tb_vec_mem_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mem_pkg.sv
// Shared types and sizing helpers for the vector memory sequencer.
package vec_mem_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
    typedef enum logic {OP_RD, OP_WR} op_e;

    function automatic int lane_w(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

endpackage

// File: rtl/vec_mem_sequencer_lane_timeout_counter.sv
// Per-lane wait-state counter; reach_o flags the edge on which the count hits TO.
module lane_timeout_counter #(
    parameter int TO = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic reach_o
);

    localparam int CW = $clog2(TO + 1);

    logic [CW-1:0] cnt_q;

    assign reach_o = en_i && (cnt_q == CW'(TO - 1));

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/vec_mem_sequencer.sv
// Serializes one R-lane vector load/store onto an N-bit memory port, stalling the pipeline meanwhile.
module vec_mem_sequencer
    import vec_mem_pkg::*;
#(
    parameter int N  = 8,
    parameter int R  = 6,
    parameter int A  = 32,
    parameter int TO = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [A-1:0]          AddrM,
    input  logic [R-1:0][N-1:0]   WriteDataM,
    output logic [R-1:0][N-1:0]   ReadDataM,
    output logic                  StallM,
    output logic                  MemErr,
    output logic [A-1:0]          mem_addr,
    output logic [N-1:0]          mem_wdata,
    output logic                  mem_re,
    output logic                  mem_we,
    input  logic [N-1:0]          mem_rdata,
    input  logic                  mem_ready
);

    localparam int LW = lane_w(R);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [A-1:0]       base_q, base_d;
    logic [R-1:0][N-1:0] wbuf_q, wbuf_d;
    logic [R-1:0][N-1:0] rbuf_q, rbuf_d;
    logic [R-1:0][N-1:0] rdata_q, rdata_d;
    logic [LW-1:0]      lane_q, lane_d;
    logic               err_q, err_d;
    logic               tmo_en, tmo_clr, tmo_reach;

    lane_timeout_counter #(.TO(TO)) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (tmo_clr),
        .en_i    (tmo_en),
        .reach_o (tmo_reach)
    );

    assign tmo_clr   = (state_q != ACCESS) || mem_ready || tmo_reach;
    assign ReadDataM = rdata_q;
    assign MemErr    = err_q;

    always_comb begin
        // NOTE: every _d and output gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        op_d      = op_q;
        base_d    = base_q;
        wbuf_d    = wbuf_q;
        rbuf_d    = rbuf_q;
        rdata_d   = rdata_q;
        lane_d    = lane_q;
        err_d     = err_q;
        StallM    = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        tmo_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (MemReadM || MemWriteM) begin
                    // A pending request must not stall the pipeline while reset holds it.
                    StallM  = !reset;
                    base_d  = AddrM;
                    wbuf_d  = WriteDataM;
                    op_d    = MemWriteM ? OP_WR : OP_RD;
                    lane_d  = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                StallM    = 1'b1;
                mem_addr  = base_q + A'(lane_q);
                mem_wdata = wbuf_q[lane_q];
                mem_we    = (op_q == OP_WR);
                mem_re    = (op_q == OP_RD);
                tmo_en    = !mem_ready;
                if (mem_ready) begin
                    if (op_q == OP_RD) rbuf_d[lane_q] = mem_rdata;
                    if (lane_q == LW'(R - 1)) state_d = DONE;
                    else                      lane_d  = lane_q + LW'(1);
                end else if (tmo_reach) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (op_q == OP_RD) rdata_d = rbuf_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_RD;
            base_q  <= '0;
            // NOTE: the lane buffers are reset as well so an abandoned access never leaks into ReadDataM.
            wbuf_q  <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
            lane_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only, so every register samples pre-edge values.
            state_q <= state_d;
            op_q    <= op_d;
            base_q  <= base_d;
            wbuf_q  <= wbuf_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
            lane_q  <= lane_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Scoreboard bench: stimulus queues expected lane beats and completions, a monitor pops and compares.
`timescale 1ns/1ps
module tb_vec_mem_sequencer;

    localparam int N  = 8;
    localparam int R  = 6;
    localparam int A  = 32;
    localparam int TO = 15;

    logic               clk = 1'b0;
    logic               reset;
    logic               MemReadM, MemWriteM;
    logic [A-1:0]       AddrM;
    logic [R*N-1:0]     WriteDataM;
    logic [R*N-1:0]     ReadDataM;
    logic               StallM, MemErr;
    logic [A-1:0]       mem_addr;
    logic [N-1:0]       mem_wdata;
    logic               mem_re, mem_we;
    logic [N-1:0]       mem_rdata;
    logic               mem_ready;

    vec_mem_sequencer #(.N(N), .R(R), .A(A), .TO(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .AddrM      (AddrM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MemErr     (MemErr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    // Memory model: data is the low address byte; ready pattern chosen by mode.
    int          mode = 0;             // 0 always ready, 1 every 3rd cycle, 2 stuck at stuck_addr
    logic [A-1:0] stuck_addr = '0;
    logic [1:0]  wc = 2'd0;

    assign mem_rdata = mem_addr[N-1:0];
    assign mem_ready = (mode == 0) ? 1'b1 :
                       (mode == 1) ? (wc == 2'd2) :
                                     (mem_addr != stuck_addr);

    always @(negedge clk) begin
        if (mem_re || mem_we) wc <= mem_ready ? 2'd0 : wc + 2'd1;
        else                  wc <= 2'd0;
    end

    typedef struct {
        logic [A-1:0] addr;
        logic [N-1:0] wdata;
        logic         wr;
    } lane_exp_t;

    typedef struct {
        int           stall;
        logic [R*N-1:0] rdata;
        logic         err;
    } done_exp_t;

    lane_exp_t lane_sb[$];
    done_exp_t done_sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [N-1:0]   model_rbuf [R];
    logic [R*N-1:0] model_rdata = '0;
    logic           model_err   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [R*N-1:0] pack_rbuf();
        logic [R*N-1:0] v;
        for (int i = 0; i < R; i++) v[i*N +: N] = model_rbuf[i];
        return v;
    endfunction

    // Issue one access, queue its expected beats and completion, hold the request until StallM drops.
    task automatic do_access(input logic rd, input logic wr, input logic [A-1:0] addr,
                             input logic [R*N-1:0] wdata, input int exp_stall, input int stuck_lane);
        int        nl;
        lane_exp_t le;
        done_exp_t de;
        logic      seen_low;
        logic [A-1:0] la;
        nl = (stuck_lane < 0) ? R : stuck_lane;
        for (int i = 0; i < nl; i++) begin
            la       = addr + A'(i);
            le.addr  = la;
            le.wdata = wdata[i*N +: N];
            le.wr    = wr;
            lane_sb.push_back(le);
            if (!wr) model_rbuf[i] = la[N-1:0];
        end
        if (stuck_lane >= 0) model_err = 1'b1;
        if (!wr) model_rdata = pack_rbuf();
        de.stall = exp_stall;
        de.rdata = model_rdata;
        de.err   = model_err;
        done_sb.push_back(de);

        @(posedge clk); #1;
        MemReadM   = rd;
        MemWriteM  = wr;
        AddrM      = addr;
        WriteDataM = wdata;
        #1;
        seen_low = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (!StallM) begin
                seen_low = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        check("stall_release", seen_low, 1'b1);
    endtask

    // Monitor: samples mid-cycle, between the input drive and the falling edge.
    initial begin
        logic      prev_stall = 1'b0;
        logic      pend = 1'b0;
        int        stall_cnt = 0;
        int        saved = 0;
        lane_exp_t le;
        done_exp_t de;
        forever begin
            @(posedge clk); #2;
            if (reset) begin
                prev_stall = 1'b0;
                pend       = 1'b0;
                stall_cnt  = 0;
            end else begin
                if (pend) begin
                    pend = 1'b0;
                    check("done_expected", done_sb.size() != 0, 1'b1);
                    if (done_sb.size() != 0) begin
                        de = done_sb.pop_front();
                        check("stall_cycles", saved, de.stall);
                        check("ReadDataM", ReadDataM, de.rdata);
                        check("MemErr", MemErr, de.err);
                    end
                end
                if ((mem_re || mem_we) && mem_ready) begin
                    check("lane_expected", lane_sb.size() != 0, 1'b1);
                    if (lane_sb.size() != 0) begin
                        le = lane_sb.pop_front();
                        check("mem_addr", mem_addr, le.addr);
                        check("mem_we", mem_we, le.wr);
                        check("mem_re", mem_re, !le.wr);
                        if (le.wr) check("mem_wdata", mem_wdata, le.wdata);
                    end
                end
                if (StallM) begin
                    stall_cnt++;
                end else if (prev_stall) begin
                    pend      = 1'b1;
                    saved     = stall_cnt;
                    stall_cnt = 0;
                end
                prev_stall = StallM;
            end
        end
    end

    initial begin
        lane_exp_t le;
        for (int i = 0; i < R; i++) model_rbuf[i] = '0;
        reset      = 1'b1;
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        AddrM      = '0;
        WriteDataM = '0;

        @(posedge clk); #2;
        check("rst_ReadDataM", ReadDataM, '0);
        check("rst_StallM", StallM, 1'b0);
        check("rst_MemErr", MemErr, 1'b0);
        check("rst_mem_re", mem_re, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_wdata, '0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: load, memory always ready
        mode = 0;
        do_access(1'b1, 1'b0, 32'h0000_0100, '0, 7, -1);
        // 2: store with two wait states per lane
        mode = 1;
        do_access(1'b0, 1'b1, 32'h0000_0180, 48'hA5A4A3A2A1A0, 19, -1);
        // 3: read and write together: the store wins
        mode = 0;
        do_access(1'b1, 1'b1, 32'h0000_01C0, 48'hB5B4B3B2B1B0, 7, -1);
        // 4: address wrap-around
        do_access(1'b1, 1'b0, 32'hFFFF_FFFE, '0, 7, -1);
        // 5: lane 2 never ready -> timeout, then a good access keeps MemErr set
        mode       = 2;
        stuck_addr = 32'h0000_0212;
        do_access(1'b1, 1'b0, 32'h0000_0210, '0, 18, 2);
        mode = 0;
        do_access(1'b1, 1'b0, 32'h0000_0320, '0, 7, -1);

        // 6: reset while lane 3 is in flight
        for (int i = 0; i < 3; i++) begin
            le.addr  = 32'h0000_0400 + A'(i);
            le.wdata = '0;
            le.wr    = 1'b0;
            lane_sb.push_back(le);
        end
        @(posedge clk); #1;
        MemReadM = 1'b1;
        AddrM    = 32'h0000_0400;
        repeat (4) @(posedge clk);
        #1;
        check("rst6_lane3_addr", mem_addr, 32'h0000_0403);
        reset    = 1'b1;
        MemReadM = 1'b0;
        #1;
        check("rst6_StallM", StallM, 1'b0);
        check("rst6_mem_re", mem_re, 1'b0);
        check("rst6_MemErr", MemErr, 1'b0);
        check("rst6_ReadDataM", ReadDataM, '0);
        check("rst6_mem_addr", mem_addr, '0);
        for (int i = 0; i < R; i++) model_rbuf[i] = '0;
        model_rdata = '0;
        model_err   = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        do_access(1'b1, 1'b0, 32'h0000_0500, '0, 7, -1);

        repeat (3) @(posedge clk);
        #3;
        check("lane_sb_drained", lane_sb.size(), 0);
        check("done_sb_drained", done_sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
